puf_auth_verifier: RTL

Consumer end of the PUF response path: it accepts 8-bit puf_response words from the comparator stage.
- Enrollment: stores a majority-voted golden response per challenge slot.
- Verification: compares a fresh response against the stored golden word by Hamming distance and issues pass/fail.
- Sits between the RO comparator and the host/authentication controller.

---
 rtl/puf_auth_verifier.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/puf_auth_verifier.sv
// PUF response verifier: majority-voted enrollment of golden words per challenge slot and
// Hamming-distance verification. Optional consecutive-failure lockout under `FAIL_LOCK_EN.
module puf_auth_verifier #(
  parameter int unsigned RESP_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned HD_THRESH = 2,
  parameter int unsigned NSAMP     = 3,
  parameter int unsigned MAX_FAILS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] challenge_id,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] puf_response,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [3:0]        hd_out,
  output logic              err,
  output logic              locked
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0]  HdThresh = 4'(HD_THRESH);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StCompute = 2'd2;
  localparam logic [1:0] StReport  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              mode_q;
  logic [ADDR_W-1:0] id_q;
  logic [1:0]        cnt_q;
  logic [RESP_W-1:0] samp_q [3];
  logic [RESP_W-1:0] golden_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic              done_q, pass_q, err_q;
  logic [3:0]        hd_q;

  logic              accept, capture, capture_last, compute_fire;
  logic [1:0]        cnt_inc, last_cnt;
  logic              slot_valid, hd_ok, pass_v, lock_force;
  logic [RESP_W-1:0] golden_rd, diff, majority;
  logic [3:0]        hd_d;

  // A start coinciding with the done pulse is dropped, even though the FSM is already idle.
  assign accept       = (state_q == StIdle) && enable && start && !done_q;
  assign capture      = (state_q == StCollect) && enable && resp_valid;
  assign cnt_inc      = cnt_q + 2'd1;
  assign last_cnt     = mode_q ? 2'd1 : 2'(NSAMP);
  assign capture_last = capture && (cnt_inc == last_cnt);
  assign compute_fire = (state_q == StCompute) && enable;

  assign golden_rd  = golden_q[id_q];
  assign slot_valid = valid_q[id_q];
  assign diff       = samp_q[0] ^ golden_rd;
  assign majority   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                      (samp_q[1] & samp_q[2]);

  always_comb begin
    hd_d = '0;
    for (int unsigned i = 0; i < RESP_W; i++) begin
      hd_d = hd_d + {3'b000, diff[i]};
    end
  end

  assign hd_ok  = (hd_d <= HdThresh);
  assign pass_v = slot_valid && hd_ok && !lock_force;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (accept)       state_d = StCollect;
      StCollect: if (capture_last) state_d = StCompute;
      StCompute: if (enable)       state_d = StReport;
      StReport:  if (enable)       state_d = StIdle;
      default:                     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
      hd_q    <= '0;
      for (int i = 0; i < 3; i++) samp_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StReport) && enable;
      if (accept) begin
        mode_q <= mode;
        id_q   <= challenge_id;
        cnt_q  <= '0;
        pass_q <= 1'b0;
        err_q  <= 1'b0;
        hd_q   <= '0;
      end
      if (capture) begin
        samp_q[cnt_q] <= puf_response;
        cnt_q         <= cnt_inc;
      end
      if (compute_fire) begin
        if (!mode_q) begin
          valid_q[id_q] <= 1'b1;
          pass_q        <= 1'b1;
          err_q         <= 1'b0;
          hd_q          <= '0;
        end else begin
          pass_q <= pass_v;
          err_q  <= !slot_valid;
          hd_q   <= slot_valid ? hd_d : 4'd0;
        end
      end
    end
  end

  // Golden storage is not reset; the valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (compute_fire && !mode_q) golden_q[id_q] <= majority;
  end

`ifdef FAIL_LOCK_EN
  localparam int unsigned FailW = $clog2(MAX_FAILS + 1);

  logic [FailW-1:0] fail_cnt_q, fail_next;
  logic             locked_q;
  logic             verify_hit;

  assign verify_hit = compute_fire && mode_q && slot_valid;

  always_comb begin
    fail_next = fail_cnt_q;
    if (verify_hit) begin
      if (hd_ok) begin
        fail_next = '0;
      end else if (fail_cnt_q != FailW'(MAX_FAILS)) begin
        fail_next = fail_cnt_q + FailW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      fail_cnt_q <= fail_next;
      if (fail_next == FailW'(MAX_FAILS)) locked_q <= 1'b1;
    end
  end

  assign lock_force = locked_q;
  assign locked     = locked_q;
`else
  logic [31:0] unused_max_fails;
  assign unused_max_fails = MAX_FAILS;
  assign lock_force       = 1'b0;
  assign locked           = 1'b0;
`endif

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign pass   = pass_q;
  assign err    = err_q;
  assign hd_out = hd_q;

endmodule
